// File: rtl/vec_ctrl_pkg.sv
// Shared types and constants for the vector control sequencer.
package vec_ctrl_pkg;

  localparam int unsigned CTRL_W = 12;
  localparam int unsigned ALU_W  = 3;

  localparam logic [3:0] OP_MUL   = 4'h0;
  localparam logic [3:0] OP_DIV   = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'h4;
  localparam logic [3:0] OP_SUB   = 4'h5;
  localparam logic [3:0] OP_ADDI  = 4'h6;
  localparam logic [3:0] OP_SUBI  = 4'h7;
  localparam logic [3:0] OP_B     = 4'h8;
  localparam logic [3:0] OP_BEQ   = 4'h9;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_MUL = 3'b001,
    ALU_DIV = 3'b010,
    ALU_CMP = 3'b011,
    ALU_SUB = 3'b100
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    LAT_ONE,
    LAT_MUL,
    LAT_DIV
  } lat_class_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  typedef struct packed {
    logic reg_write;
    logic alu_src;
    logic pc_src;
    logic imm_src;
    logic flag_update;
    logic mem_to_reg;
    logic mem_write;
    logic ra2_src;
    logic ra1_src;
    logic alu_src1;
    logic alu_src2;
    logic zero_to_alu;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_RST = ctrl_word_t'(12'b000001000000);

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vec_op_decode.sv
// Combinational opcode decoder: control word, ALU op, vector/scalar, latency class.
module vec_op_decode
  import vec_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output ctrl_word_t          ctrl_o,
  output alu_ctrl_t           alu_o,
  output logic                is_vector_o,
  output logic                is_illegal_o,
  output lat_class_t          lat_o
);

  logic hi_nz;

  // Any set bit above the decoded nibble makes the opcode illegal.
  assign hi_nz = |(opcode_i >> 4);

  // Decode table lookup.
  always_comb begin
    ctrl_o       = CTRL_RST;
    alu_o        = ALU_ADD;
    is_vector_o  = 1'b1;
    is_illegal_o = 1'b0;
    lat_o        = LAT_ONE;
    unique case (opcode_i[3:0])
      OP_MUL:   begin ctrl_o = ctrl_word_t'(12'b100011000010); alu_o = ALU_MUL; lat_o = LAT_MUL; end
      OP_DIV:   begin ctrl_o = ctrl_word_t'(12'b100011000010); alu_o = ALU_DIV; lat_o = LAT_DIV; end
      OP_LOAD:  ctrl_o = ctrl_word_t'(12'b110110000101);
      OP_STORE: ctrl_o = ctrl_word_t'(12'b010100110101);
      OP_ADD:   ctrl_o = ctrl_word_t'(12'b100011000000);
      OP_SUB:   begin ctrl_o = ctrl_word_t'(12'b100011000000); alu_o = ALU_SUB; end
      OP_ADDI:  ctrl_o = ctrl_word_t'(12'b110011000101);
      OP_SUBI:  begin ctrl_o = ctrl_word_t'(12'b110011000101); alu_o = ALU_SUB; end
      OP_B:     begin ctrl_o = ctrl_word_t'(12'b011011011101); is_vector_o = 1'b0; end
      OP_BEQ:   begin ctrl_o = ctrl_word_t'(12'b001011000000); alu_o = ALU_CMP; is_vector_o = 1'b0; end
      default:  is_illegal_o = 1'b1;
    endcase
    if (hi_nz) is_illegal_o = 1'b1;
  end

endmodule

// File: rtl/vec_ctrl_sequencer.sv
// Registered decode + beat sequencer between fetch and vector execute.
// Optional build macro VEC_CTRL_PERF_EN adds instruction and stall counters.
module vec_ctrl_sequencer
  import vec_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W  = 4,
  parameter int unsigned NUM_ELEMS = 8,
  parameter int unsigned LANES     = 2,
  parameter int unsigned MUL_LAT   = 2,
  parameter int unsigned DIV_LAT   = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                instr_valid,
  output logic                                instr_ready,
  input  logic [OPCODE_W-1:0]                 opcode,
  input  logic                                flush,
  input  logic                                ex_ready,
  output logic                                out_valid,
  output logic [11:0]                         ctrl,
  output logic [2:0]                          alu_control,
  output logic [clog2_min1(NUM_ELEMS)-1:0]    elem_idx,
  output logic                                last_beat,
  output logic                                busy,
  output logic                                illegal_op
`ifdef VEC_CTRL_PERF_EN
  ,
  output logic [31:0]                         perf_instr_cnt,
  output logic [31:0]                         perf_stall_cnt
`endif
);

  localparam int unsigned EW      = clog2_min1(NUM_ELEMS);
  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CW      = clog2_min1(MAX_LAT);

  ctrl_word_t dec_ctrl;
  alu_ctrl_t  dec_alu;
  logic       dec_vec;
  logic       dec_ill;
  lat_class_t dec_lat;

  state_t         state_q, state_d;
  logic           out_valid_q, out_valid_d;
  ctrl_word_t     ctrl_q, ctrl_d;
  alu_ctrl_t      alu_q, alu_d;
  logic [EW-1:0]  elem_idx_q, elem_idx_d;
  logic           last_beat_q, last_beat_d;
  logic           busy_q, busy_d;
  logic           illegal_q, illegal_d;
  lat_class_t     lat_q, lat_d;
  logic [CW-1:0]  wait_cnt_q, wait_cnt_d;

  logic           beat_done;
  logic [EW-1:0]  next_idx;
  int unsigned    lat_len;

  vec_op_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode_i     (opcode),
    .ctrl_o       (dec_ctrl),
    .alu_o        (dec_alu),
    .is_vector_o  (dec_vec),
    .is_illegal_o (dec_ill),
    .lat_o        (dec_lat)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    alu_d       = alu_q;
    elem_idx_d  = elem_idx_q;
    last_beat_d = last_beat_q;
    lat_d       = lat_q;
    wait_cnt_d  = wait_cnt_q;
    illegal_d   = 1'b0;
    beat_done   = out_valid_q && ex_ready;
    next_idx    = elem_idx_q + EW'(LANES);
    unique case (lat_q)
      LAT_MUL: lat_len = MUL_LAT;
      LAT_DIV: lat_len = DIV_LAT;
      default: lat_len = 1;
    endcase

    if (flush) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      elem_idx_d  = '0;
      last_beat_d = 1'b0;
      wait_cnt_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (instr_valid) begin
            if (dec_ill) begin
              illegal_d = 1'b1;
            end else begin
              state_d     = ISSUE;
              out_valid_d = 1'b1;
              ctrl_d      = dec_ctrl;
              alu_d       = dec_alu;
              lat_d       = dec_lat;
              elem_idx_d  = '0;
              last_beat_d = dec_vec ? (NUM_ELEMS == LANES) : 1'b1;
            end
          end
        end
        ISSUE: begin
          if (beat_done) begin
            if (last_beat_q) begin
              state_d     = IDLE;
              out_valid_d = 1'b0;
              elem_idx_d  = '0;
              last_beat_d = 1'b0;
            end else begin
              elem_idx_d  = next_idx;
              last_beat_d = (next_idx == EW'(NUM_ELEMS - LANES));
              if (lat_len > 1) begin
                state_d     = WAIT;
                out_valid_d = 1'b0;
                wait_cnt_d  = CW'(lat_len - 2);
              end
            end
          end
        end
        WAIT: begin
          if (wait_cnt_q == '0) begin
            state_d     = ISSUE;
            out_valid_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q - CW'(1);
          end
        end
        default: begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      ctrl_q      <= CTRL_RST;
      alu_q       <= ALU_ADD;
      elem_idx_q  <= '0;
      last_beat_q <= 1'b0;
      busy_q      <= 1'b0;
      illegal_q   <= 1'b0;
      lat_q       <= LAT_ONE;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      alu_q       <= alu_d;
      elem_idx_q  <= elem_idx_d;
      last_beat_q <= last_beat_d;
      busy_q      <= busy_d;
      illegal_q   <= illegal_d;
      lat_q       <= lat_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign ctrl        = ctrl_q;
  assign alu_control = alu_q;
  assign elem_idx    = elem_idx_q;
  assign last_beat   = last_beat_q;
  assign busy        = busy_q;
  assign illegal_op  = illegal_q;

`ifdef VEC_CTRL_PERF_EN
  logic [31:0] perf_instr_q, perf_stall_q;
  logic        accept;

  assign accept = (state_q == IDLE) && instr_valid && !flush && !dec_ill;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_instr_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (accept)                   perf_instr_q <= perf_instr_q + 32'd1;
      if (out_valid_q && !ex_ready) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_instr_cnt = perf_instr_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_vec_ctrl_sequencer.sv
// Scoreboard bench for vec_ctrl_sequencer: reference beat list per instruction, monitor compares.
module tb_vec_ctrl_sequencer;

  localparam int unsigned NE = 8;
  localparam int unsigned LN = 2;
  localparam int unsigned ML = 2;
  localparam int unsigned DL = 4;

  typedef struct {
    logic [11:0] ctrl;
    logic [2:0]  alu;
    logic [2:0]  idx;
    logic        last;
    int          gap;
  } beat_t;

  logic        clk, rst, instr_valid, instr_ready, flush, ex_ready;
  logic [3:0]  opcode;
  logic        out_valid, last_beat, busy, illegal_op;
  logic [11:0] ctrl;
  logic [2:0]  alu_control;
  logic [2:0]  elem_idx;
`ifdef VEC_CTRL_PERF_EN
  logic [31:0] perf_instr_cnt, perf_stall_cnt;
`endif

  vec_ctrl_sequencer #(
    .OPCODE_W(4), .NUM_ELEMS(NE), .LANES(LN), .MUL_LAT(ML), .DIV_LAT(DL)
  ) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .flush(flush), .ex_ready(ex_ready), .out_valid(out_valid),
    .ctrl(ctrl), .alu_control(alu_control), .elem_idx(elem_idx),
    .last_beat(last_beat), .busy(busy), .illegal_op(illegal_op)
`ifdef VEC_CTRL_PERF_EN
    , .perf_instr_cnt(perf_instr_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  beat_t exp_q[$];
  int    ill_exp  = 0;
  int    ill_seen = 0;
  logic  rdy_mode  = 1'b0;
  logic  rdy_force = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expand an opcode into its list of beats.
  task automatic push_op(input logic [3:0] op);
    logic [11:0] c;
    logic [2:0]  a;
    int          nbeats, lat;
    beat_t       b;
    lat = 1; nbeats = NE / LN; a = 3'b000; c = 12'b0;
    case (op)
      4'd0: begin c = 12'b100011000010; a = 3'b001; lat = ML; end
      4'd1: begin c = 12'b100011000010; a = 3'b010; lat = DL; end
      4'd2: c = 12'b110110000101;
      4'd3: c = 12'b010100110101;
      4'd4: c = 12'b100011000000;
      4'd5: begin c = 12'b100011000000; a = 3'b100; end
      4'd6: c = 12'b110011000101;
      4'd7: begin c = 12'b110011000101; a = 3'b100; end
      4'd8: begin c = 12'b011011011101; nbeats = 1; end
      4'd9: begin c = 12'b001011000000; a = 3'b011; nbeats = 1; end
      default: nbeats = 0;
    endcase
    if (nbeats == 0) ill_exp++;
    for (int k = 0; k < nbeats; k++) begin
      b.ctrl = c; b.alu = a; b.idx = 3'(k * LN); b.last = (k == nbeats - 1);
      b.gap  = (k == 0) ? 1 : lat;
      exp_q.push_back(b);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [3:0] op);
    int n = 0;
    while (!instr_ready && n < 500) begin tick(); n++; end
    check("issue_ready", instr_ready, 1'b1);
    instr_valid = 1'b1; opcode = op;
    push_op(op);
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(exp_q.size() == 0 && instr_ready) && n < 1000) begin tick(); n++; end
    check("drain", (exp_q.size() == 0) && instr_ready, 1'b1);
  endtask

  // ex_ready driver: forced level or random back-pressure.
  always @(posedge clk) begin
    #2;
    ex_ready = rdy_mode ? ($urandom_range(0, 3) != 0) : rdy_force;
  end

  // Monitor: compares every presented beat against the scoreboard head.
  int    since = 0;
  logic  presenting = 1'b0;
  logic  ready_next = 1'b0;
  logic  ill_prev = 1'b0;
  beat_t e;
  always @(negedge clk) begin
    if (rst) begin
      presenting = 1'b0; since = 0; ready_next = 1'b0; ill_prev = 1'b0;
    end else begin
      since++;
      if (ready_next) begin
        check("ready_after_last", instr_ready, 1'b1);
        ready_next = 1'b0;
      end
      if (illegal_op) begin
        check("illegal_unexpected", ill_seen < ill_exp, 1'b1);
        check("illegal_one_cycle", ill_prev, 1'b0);
        ill_seen++;
      end
      ill_prev = illegal_op;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", out_valid, 1'b0);
        end else begin
          e = exp_q[0];
          if (presenting)
            check("beat_hold", {ctrl, alu_control, elem_idx, last_beat, busy, instr_ready},
                  {e.ctrl, e.alu, e.idx, e.last, 1'b1, 1'b0});
          else begin
            check("beat", {ctrl, alu_control, elem_idx, last_beat, busy, instr_ready},
                  {e.ctrl, e.alu, e.idx, e.last, 1'b1, 1'b0});
            check("beat_gap", since, e.gap);
          end
          presenting = 1'b1;
          if (ex_ready) begin
            void'(exp_q.pop_front());
            presenting = 1'b0;
            since = 0;
            if (e.last) ready_next = 1'b1;
          end
        end
      end else if (presenting) begin
        check("beat_withdrawn", out_valid, 1'b1);
        presenting = 1'b0;
      end
      if (instr_valid && instr_ready && !flush) since = 0;
    end
  end

  initial begin
    logic found;
    logic [3:0] op;
    rst = 1'b1; instr_valid = 1'b0; opcode = 4'd0; flush = 1'b0; ex_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {out_valid, ctrl, alu_control, elem_idx, last_beat, busy, illegal_op},
          {1'b0, 12'b000001000000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", instr_ready, 1'b1);
    tick();

    // Directed: add, mul, div, BEQ, B, load, store with no back-pressure.
    issue(4'h4); wait_idle();
    issue(4'h0); wait_idle();
    issue(4'h1); wait_idle();
    issue(4'h9); wait_idle();
    issue(4'h8); wait_idle();
    issue(4'h2); wait_idle();
    issue(4'h3); wait_idle();

    // sub with three stall cycles on the elem_idx=2 beat.
    issue(4'h5);
    tick(); rdy_force = 1'b0;
    repeat (3) tick();
    rdy_force = 1'b1;
    wait_idle();

    // Illegal opcode then an immediately following legal one.
    issue(4'hF);
    issue(4'h6);
    wait_idle();

    // flush in IDLE blocks acceptance.
    instr_valid = 1'b1; opcode = 4'h4; flush = 1'b1;
    tick();
    instr_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_idle", {out_valid, busy, instr_ready}, 3'b001);
    tick();

    // flush during a div wait state.
    issue(4'h1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_wait", {out_valid, busy, elem_idx}, 5'b0);
    tick();

    // Reset while issuing the elem_idx=4 beat.
    issue(4'h4);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (out_valid && elem_idx == 3'd4) found = 1'b1;
    end
    check("rst_reach_idx4", found, 1'b1);
    #1 rst = 1'b1;
    #1 check("rst_mid", {out_valid, busy, elem_idx, last_beat}, 6'b0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst_mid", instr_ready, 1'b1);
    tick();
    issue(4'h7); wait_idle();

    // Randomised instructions with random back-pressure.
    rdy_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      if ($urandom_range(0, 5) == 0) op = 4'($urandom_range(10, 15));
      else                           op = 4'($urandom_range(0, 9));
      issue(op);
    end
    wait_idle();
    rdy_mode = 1'b0;
    repeat (3) tick();

    check("illegal_count", ill_seen, ill_exp);
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
